// File: rtl/nway_cache_ctrl_pkg.sv
// Shared definitions for the n-way cache controller: bus structs,
// replacement policy selector, controller states and sizing helpers.
package cache_def;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        REPL_LRU,
        REPL_MRU,
        REPL_FIFO
    } repl_policy_t;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE_TAG,
        ALLOCATE,
        WRITE_BACK
    } cache_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
        logic              rw;
        logic              valid;
    } cpu_req_t;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              ready;
    } cpu_res_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
        logic              rw;
        logic              valid;
    } mem_req_t;

    typedef struct packed {
        logic [LINE_W-1:0] data;
        logic              ready;
    } mem_data_t;

    // Way-index width; a direct-mapped cache still carries a 1-bit way index.
    function automatic int way_bits(input int n_ways);
        return (n_ways > 1) ? $clog2(n_ways) : 1;
    endfunction

endpackage

// File: rtl/nway_cache_ctrl_if.sv
// CPU-side and memory-side buses of the cache controller; the controller
// takes the slave view, the CPU/memory environment the master view.
interface nway_cache_ctrl_if;
    import cache_def::*;

    cpu_req_t  cpu_req;
    cpu_res_t  cpu_res;
    mem_req_t  mem_req;
    mem_data_t mem_data;

    modport master (
        output cpu_req,
        output mem_data,
        input  cpu_res,
        input  mem_req
    );

    modport slave (
        input  cpu_req,
        input  mem_data,
        output cpu_res,
        output mem_req
    );

endinterface

// File: rtl/nway_cache_ctrl_repl.sv
// Per-set replacement state (recency ranks and FIFO pointers) and the
// policy-selected victim for the currently indexed set.
module cache_repl_unit
    import cache_def::*;
#(
    parameter int           N_WAYS = 4,
    parameter int           N_SETS = 1024,
    parameter repl_policy_t POLICY = REPL_LRU,
    localparam int          WAY_W  = way_bits(N_WAYS),
    localparam int          IDX_W  = $clog2(N_SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] index,
    input  logic [WAY_W-1:0] hit_way,
    input  logic             access,
    input  logic             fill,
    output logic [WAY_W-1:0] victim
);

    logic [WAY_W-1:0] rank     [N_SETS][N_WAYS];
    logic [WAY_W-1:0] fifo_ptr [N_SETS];
    logic [WAY_W-1:0] hit_rank;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] mru_way;

    assign hit_rank = rank[index][hit_way];

    // NOTE: give every always_comb output a default before any branch so no path leaves it unassigned (no latches).
    always_comb begin
        lru_way = '0;
        mru_way = '0;
        for (int w = 0; w < N_WAYS; w++) begin
            if (rank[index][w] == WAY_W'(N_WAYS - 1)) lru_way = WAY_W'(w);
            if (rank[index][w] == '0)                 mru_way = WAY_W'(w);
        end
    end

    // With one way every rank and pointer is stuck at 0, so all policies pick way 0.
    always_comb begin
        case (POLICY)
            REPL_MRU:  victim = mru_way;
            REPL_FIFO: victim = fifo_ptr[index];
            default:   victim = lru_way;
        endcase
    end

    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < N_SETS; s++) begin
                fifo_ptr[s] <= '0;
                for (int w = 0; w < N_WAYS; w++) rank[s][w] <= WAY_W'(w);
            end
        end else begin
            if (access) begin
                for (int w = 0; w < N_WAYS; w++) begin
                    if (WAY_W'(w) == hit_way)          rank[index][w] <= '0;
                    else if (rank[index][w] < hit_rank) rank[index][w] <= rank[index][w] + 1'b1;
                end
            end
            if (fill) begin
                fifo_ptr[index] <= (fifo_ptr[index] == WAY_W'(N_WAYS - 1)) ? '0
                                                                           : fifo_ptr[index] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nway_cache_ctrl.sv
// N-way set-associative write-back cache controller: tag compare, victim
// write-back, line allocation and re-compare, with pluggable replacement.
module nway_cache_ctrl
    import cache_def::*;
#(
    parameter int           N_WAYS = 4,
    parameter int           N_SETS = 1024,
    parameter repl_policy_t POLICY = REPL_LRU,
    localparam int          WAY_W  = way_bits(N_WAYS),
    localparam int          IDX_W  = $clog2(N_SETS),
    localparam int          TAG_W  = ADDR_W - IDX_W - 4
) (
    input logic              clk,
    input logic              rst,
    nway_cache_ctrl_if.slave bus
);

    cache_state_t     state_q, state_n;
    mem_req_t         mem_req_q, mem_req_n;
    logic [WAY_W-1:0] victim_q, victim_n;

    logic [TAG_W-1:0]  tag_arr   [N_WAYS][N_SETS];
    logic [LINE_W-1:0] data_arr  [N_WAYS][N_SETS];
    logic [N_SETS-1:0] valid_arr [N_WAYS];
    logic [N_SETS-1:0] dirty_arr [N_WAYS];

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [1:0]        word_sel;
    logic [ADDR_W-1:0] line_addr;
    logic [ADDR_W-1:0] wb_addr;
    logic              hit, free_found, hit_go, wr_hit, fill, vic_dirty;
    logic [WAY_W-1:0]  hit_way, free_way, repl_victim, miss_victim;
    logic [LINE_W-1:0] rd_line, vic_line;
    logic [WORD_W-1:0] rd_word;

    assign req_tag   = bus.cpu_req.addr[ADDR_W-1 -: TAG_W];
    assign req_idx   = bus.cpu_req.addr[4 +: IDX_W];
    assign word_sel  = bus.cpu_req.addr[3:2];
    assign line_addr = {bus.cpu_req.addr[ADDR_W-1:4], 4'b0000};

    // Descending scan so the lowest-index match / free way wins.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (valid_arr[w][req_idx] && tag_arr[w][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_arr[w][req_idx]) begin
                free_found = 1'b1;
                free_way   = WAY_W'(w);
            end
        end
    end

    assign miss_victim = free_found ? free_way : repl_victim;
    assign vic_dirty   = valid_arr[miss_victim][req_idx] && dirty_arr[miss_victim][req_idx];
    assign vic_line    = data_arr[miss_victim][req_idx];
    assign wb_addr     = {tag_arr[miss_victim][req_idx], req_idx, 4'b0000};
    assign rd_line     = data_arr[hit_way][req_idx];
    assign rd_word     = rd_line[{word_sel, 5'b00000} +: WORD_W];

    assign hit_go = (state_q == COMPARE_TAG) && hit && !rst;
    assign wr_hit = hit_go && bus.cpu_req.rw;
    assign fill   = (state_q == ALLOCATE) && bus.mem_data.ready && !rst;

    cache_repl_unit #(
        .N_WAYS (N_WAYS),
        .N_SETS (N_SETS),
        .POLICY (POLICY)
    ) u_repl (
        .clk     (clk),
        .rst     (rst),
        .index   (req_idx),
        .hit_way (hit_way),
        .access  (hit_go),
        .fill    (fill),
        .victim  (repl_victim)
    );

    always_comb begin
        bus.cpu_res = '0;
        if (hit_go) begin
            bus.cpu_res.ready = 1'b1;
            bus.cpu_res.data  = rd_word;
        end
    end

    assign bus.mem_req = mem_req_q;

    // The memory request is registered so it stays stable until accepted.
    always_comb begin
        state_n   = state_q;
        mem_req_n = mem_req_q;
        victim_n  = victim_q;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req.valid) state_n = COMPARE_TAG;
            end
            COMPARE_TAG: begin
                if (hit) begin
                    state_n = IDLE;
                end else begin
                    victim_n = miss_victim;
                    if (vic_dirty) begin
                        mem_req_n = '{addr: wb_addr, data: vic_line, rw: 1'b1, valid: 1'b1};
                        state_n   = WRITE_BACK;
                    end else begin
                        mem_req_n = '{addr: line_addr, data: '0, rw: 1'b0, valid: 1'b1};
                        state_n   = ALLOCATE;
                    end
                end
            end
            WRITE_BACK: begin
                if (bus.mem_data.ready) begin
                    mem_req_n = '{addr: line_addr, data: '0, rw: 1'b0, valid: 1'b1};
                    state_n   = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (bus.mem_data.ready) begin
                    mem_req_n = '0;
                    state_n   = COMPARE_TAG;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mem_req_q <= '0;
            victim_q  <= '0;
        end else begin
            state_q   <= state_n;
            mem_req_q <= mem_req_n;
            victim_q  <= victim_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < N_WAYS; w++) begin
                valid_arr[w] <= '0;
                dirty_arr[w] <= '0;
            end
        end else if (fill) begin
            valid_arr[victim_q][req_idx] <= 1'b1;
            dirty_arr[victim_q][req_idx] <= 1'b0;
        end else if (wr_hit) begin
            dirty_arr[hit_way][req_idx] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays have no reset; the valid bits qualify them, so clearing those is enough.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_arr[victim_q][req_idx]  <= req_tag;
            data_arr[victim_q][req_idx] <= bus.mem_data.data;
        end else if (wr_hit) begin
            data_arr[hit_way][req_idx][{word_sel, 5'b00000} +: WORD_W] <= bus.cpu_req.data;
        end
    end

endmodule
